// File: rtl/sdes_cbc_if.sv
// rtl/sdes_cbc_if.sv - key, stream and status bundle for the S-DES CBC engine
interface sdes_cbc_if #(
    parameter int LANES = 1
) ();
    logic                 key_load;
    logic [9:0]           key_in;
    logic [8*LANES-1:0]   iv_in;
    logic                 mode_dec;
    logic                 cbc_en;
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic [7:0]           k1_out;
    logic [7:0]           k2_out;
    logic                 key_valid;

    modport slave (
        input  key_load, key_in, iv_in, mode_dec, cbc_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, k1_out, k2_out, key_valid
    );

    modport master (
        output key_load, key_in, iv_in, mode_dec, cbc_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, k1_out, k2_out, key_valid
    );
endinterface

// File: rtl/sdes_cbc_engine.sv
// rtl/sdes_cbc_engine.sv - multi-lane S-DES engine with optional CBC chaining
module sdes_cbc_engine #(
    parameter int LANES       = 1,
    parameter bit CBC_SUPPORT = 1'b1
) (
    input  logic      CLOCK_50,
    input  logic      RESET_N,
    sdes_cbc_if.slave bus
);
    localparam int W = 8 * LANES;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEYGEN = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_ROUND1 = 3'd3;
    localparam logic [2:0] S_ROUND2 = 3'd4;
    localparam logic [2:0] S_OUTPUT = 3'd5;

    // S-boxes indexed by {row, col}; row = outer input bits, col = inner bits
    localparam logic [1:0] S0_TBL [16] = '{2'd1, 2'd0, 2'd3, 2'd2,
                                           2'd3, 2'd2, 2'd1, 2'd0,
                                           2'd0, 2'd2, 2'd1, 2'd3,
                                           2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [1:0] S1_TBL [16] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                           2'd2, 2'd0, 2'd1, 2'd3,
                                           2'd3, 2'd0, 2'd1, 2'd0,
                                           2'd2, 2'd1, 2'd0, 2'd3};

    // Permutation tables use textbook positions (1 = MSB) mapped onto bit indices
    function automatic logic [9:0] f_p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    // P8 only reads positions 3..10, i.e. the low eight bits of the shifted key
    function automatic logic [7:0] f_p8(input logic [7:0] x);
        return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
    endfunction

    function automatic logic [7:0] f_ip(input logic [7:0] b);
        return {b[6], b[2], b[5], b[7], b[4], b[0], b[3], b[1]};
    endfunction

    function automatic logic [7:0] f_ipinv(input logic [7:0] b);
        return {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
    endfunction

    function automatic logic [7:0] f_fk(input logic [7:0] lr, input logic [7:0] k);
        logic [3:0] r;
        logic [7:0] t;
        logic [3:0] s;
        logic [3:0] p;
        r = lr[3:0];
        t = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
        s = {S0_TBL[{t[7], t[4], t[6], t[5]}], S1_TBL[{t[3], t[0], t[2], t[1]}]};
        p = {s[2], s[0], s[1], s[3]};
        return {lr[7:4] ^ p, r};
    endfunction

    logic [2:0]   r_state;
    logic [9:0]   r_key;
    logic [W-1:0] r_iv;
    logic         r_dec;
    logic         r_cbc;
    logic [7:0]   r_k1;
    logic [7:0]   r_k2;
    logic         r_key_valid;
    logic [W-1:0] r_chain;
    logic [W-1:0] r_in;
    logic [W-1:0] r_mid;
    logic [W-1:0] r_out;

    logic [9:0]   w_p10;
    logic [9:0]   w_ls1;
    logic [7:0]   w_ls3_lo;
    logic [7:0]   w_kfirst;
    logic [7:0]   w_ksecond;
    logic         w_cbc;
    logic         w_enc_xor;
    logic         w_dec_xor;
    logic         w_take_key;
    logic         w_out_fire;
    logic [W-1:0] w_r1;
    logic [W-1:0] w_r2;
    logic [W-1:0] w_next_chain;

    // Subkey schedule: LS-1 on each 5-bit half gives K1, a further LS-2 gives K2
    assign w_p10    = f_p10(r_key);
    assign w_ls1    = {w_p10[8:5], w_p10[9], w_p10[3:0], w_p10[4]};
    assign w_ls3_lo = {w_ls1[5], w_ls1[9:8], w_ls1[2:0], w_ls1[4:3]};

    // Decrypt runs the same network with the subkeys swapped
    assign w_kfirst  = r_dec ? r_k2 : r_k1;
    assign w_ksecond = r_dec ? r_k1 : r_k2;

    assign w_cbc     = CBC_SUPPORT && r_cbc;
    assign w_enc_xor = w_cbc && !r_dec;
    assign w_dec_xor = w_cbc && r_dec;

    // Key requests outside IDLE/READY are dropped entirely
    assign w_take_key = bus.key_load && ((r_state == S_IDLE) || (r_state == S_READY));
    assign w_out_fire = (r_state == S_OUTPUT) && bus.out_ready;

    // Encrypt chains on the produced ciphertext, decrypt on the consumed one
    assign w_next_chain = r_dec ? r_in : r_out;

    // Per-lane round logic: first half in ROUND1, second half in ROUND2
    always_comb begin
        w_r1 = '0;
        w_r2 = '0;
        for (int i = 0; i < LANES; i++) begin
            w_r1[8*i +: 8] = f_fk(f_ip(r_in[8*i +: 8] ^ (w_enc_xor ? r_chain[8*i +: 8] : 8'h00)),
                                  w_kfirst);
            w_r2[8*i +: 8] = f_ipinv(f_fk({r_mid[8*i +: 4], r_mid[8*i+4 +: 4]}, w_ksecond))
                             ^ (w_dec_xor ? r_chain[8*i +: 8] : 8'h00);
        end
    end

    // Capture key, IV and mode together with an accepted key request
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_key <= '0;
            r_iv  <= '0;
            r_dec <= 1'b0;
            r_cbc <= 1'b0;
        end else if (w_take_key) begin
            r_key <= bus.key_in;
            r_iv  <= bus.iv_in;
            r_dec <= bus.mode_dec;
            r_cbc <= bus.cbc_en;
        end
    end

    // Sequencer plus subkey, chain and block registers
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_k1        <= '0;
            r_k2        <= '0;
            r_key_valid <= 1'b0;
            r_chain     <= '0;
            r_in        <= '0;
            r_mid       <= '0;
            r_out       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.key_load) r_state <= S_KEYGEN;
                end
                S_KEYGEN: begin
                    r_k1        <= f_p8(w_ls1[7:0]);
                    r_k2        <= f_p8(w_ls3_lo);
                    r_chain     <= r_iv;
                    r_key_valid <= 1'b1;
                    r_state     <= S_READY;
                end
                S_READY: begin
                    if (bus.key_load) begin
                        r_state <= S_KEYGEN;
                    end else if (bus.in_valid) begin
                        r_in    <= bus.in_data;
                        r_state <= S_ROUND1;
                    end
                end
                S_ROUND1: begin
                    r_mid   <= w_r1;
                    r_state <= S_ROUND2;
                end
                S_ROUND2: begin
                    r_out   <= w_r2;
                    r_state <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (w_out_fire) begin
                        if (w_cbc) r_chain <= w_next_chain;
                        r_state <= S_READY;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_READY);
    assign bus.out_valid = (r_state == S_OUTPUT);
    assign bus.out_data  = r_out;
    assign bus.k1_out    = r_k1;
    assign bus.k2_out    = r_k2;
    assign bus.key_valid = r_key_valid;
endmodule
